sobel_core_sched: RTL and testbench
===================================

// Module: sobel_core_sched
// PURPOSE
//  Sequences one shared 3-tap MAC core (3 products plus a sum, 2-cycle latency) to compute a full 3x3 Sobel pixel.
//  Accepts one 3x3 window per handshake and issues 6 column beats to the core: 3 for Gx, then 3 for Gy.
//  Accumulates the core results and outputs the magnitude sat(|Gx|+|Gy|) as an 8-bit pixel with valid/ready.
//  Sits between the line-buffer window generator and the output pixel stream.
// PARAMETERS
//  PIX_W     8    pixel width; core data ports are PIX_W+1 signed
//  CORE_LAT  2    core latency, OutCoreDe to InCoreDataDe; also the flush length after reset
//  SAT_MAX   255  magnitude saturation ceiling
//  THRESH    128  binarisation threshold; used only with SOBEL_THRESH_EN
// PORTS
//  InClk          in   1   clock
//  InRst          in   1   synchronous reset, active-high
//  InWin          in   72  window; pixel(r,c) = InWin[8*(3*r+c) +: 8], r = row, c = column
//  InWinValid     in   1   window valid
//  InWinReady     out  1   window accepted when InWinValid & InWinReady
//  OutCoreData1   out  9   signed core operand, row 0 = {1'b0,pixel}
//  OutCoreData2   out  9   row 1
//  OutCoreData3   out  9   row 2
//  OutCoreK1..K3  out  3   signed kernel taps for rows 0..2
//  OutCoreDe      out  1   core beat enable
//  InCoreData     in   16  signed core result
//  InCoreDataDe   in   1   core result valid
//  OutPix         out  8   magnitude pixel
//  OutPixValid    out  1   pixel valid
//  InPixReady     in   1   downstream ready
//  OutBusy        out  1   high in any state except IDLE
// BEHAVIOUR
//  Reset values: all outputs 0, state FLUSH, accumulators 0, counters 0.
//  FSM states:
//   FLUSH: InWinReady=0 for CORE_LAT cycles; InCoreDataDe is ignored; then go to IDLE.
//   IDLE: InWinReady=1. On accept, latch the window and go to ISSUE.
//   ISSUE: 6 back-to-back beats, b=0..5, with OutCoreDe=1.
//    b=0..2 use column c=b with Gx taps; b=3..5 use column c=b-3 with Gy taps.
//    Gx taps per column: c0=(-1,-2,-1), c1=(0,0,0), c2=(1,2,1).
//    Gy taps per column: c0=(-1,0,1), c1=(-2,0,2), c2=(-1,0,1).
//    After b=5 go to DRAIN.
//   DRAIN: each InCoreDataDe increments the result counter (0..5).
//    Results 0..2 are summed into accX; results 3..5 into accY. Both accumulators are 12-bit signed, range +/-1020.
//    After result 5: OutPix = min(|accX|+|accY|, SAT_MAX), 11-bit intermediate. Go to OUT.
//   OUT: OutPixValid=1; OutPix is held stable until InPixReady.
//    On handshake: clear accumulators and counters, go to IDLE.
//  Results may arrive during ISSUE, because core latency is shorter than the 6 beats. The counter accepts them in ISSUE and DRAIN.
//  Timing: accept at cycle 0, beats at cycles 1..6, results at cycles 3..8, OutPixValid at cycle 9. Minimum rate is 1 pixel per 10 cycles.
//  InWinReady=0 outside IDLE. There is no overlap between windows.
//  InRst mid-operation: core results still in flight are discarded by FLUSH. No partial pixel is ever emitted.
//  InCoreDataDe outside ISSUE/DRAIN is an error. It is ignored, and a simulation-only assertion flags it.
// CONFIGURATION
//  SOBEL_THRESH_EN defined: OutPix = (magnitude >= THRESH) ? 8'd255 : 8'd0.
//  SOBEL_THRESH_EN undefined: OutPix is the saturated magnitude and THRESH is unused.
// STRUCTURE
//  sobel_pkg holds: state enum (FLUSH, IDLE, ISSUE, DRAIN, OUT), Gx/Gy tap constant tables, ACC_W=12, MAG_W=11.
//  Sub-module sobel_mag_sat: combinational abs, add, saturate/threshold. It is instantiated once.
//  FSM, beat/result counters, window register and accumulators live in this top level.
// TESTING
//  All windows below go through a bench model of the core (2-cycle latency).
//  1. All pixels 100 -> accX=0, accY=0, OutPix=0, OutPixValid at cycle 9.
//  2. Column 0=0, column 2=10, column 1=5 -> accX=40, accY=0, OutPix=40.
//  3. Column 0=0, column 2=255 -> accX=1020, OutPix=255 (saturated).
//  4. Row 0=0, row 2=20 -> accY=80, OutPix=80. Check the beats carry taps in order b0..b5.
//  5. InPixReady low for 5 cycles in OUT -> OutPix/OutPixValid held. InWinReady stays 0 until the handshake.
//  6. InRst at beat 3 -> outputs 0, FLUSH lasts 2 cycles, in-flight results ignored. The next window (case 2) gives 40.
//  With SOBEL_THRESH_EN: case 2 -> 0, case 3 -> 255.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel core scheduler: FSM states,
// Gx/Gy kernel tap tables and accumulator/magnitude widths.
package sobel_pkg;

   typedef enum logic [2:0] {
      ST_FLUSH,
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_OUT
   } state_t;

   localparam int ACC_W = 12;
   localparam int MAG_W = 11;
   localparam int TAP_W = 3;

   // Entry index is 3*column + row; taps are 3-bit two's complement.
   localparam logic [8:0][TAP_W-1:0] GX_TAPS = {
      3'b001, 3'b010, 3'b001,
      3'b000, 3'b000, 3'b000,
      3'b111, 3'b110, 3'b111
   };
   localparam logic [8:0][TAP_W-1:0] GY_TAPS = {
      3'b001, 3'b000, 3'b111,
      3'b010, 3'b000, 3'b110,
      3'b001, 3'b000, 3'b111
   };

   function automatic logic [TAP_W-1:0] sobel_tap(input logic       is_y,
                                                  input logic [1:0] col,
                                                  input logic [1:0] row);
      logic [3:0] idx;
      idx = 4'(col) * 4'd3 + 4'(row);
      return is_y ? GY_TAPS[idx] : GX_TAPS[idx];
   endfunction

endpackage

// File: rtl/sobel_mag_sat.sv
// Combinational |Gx|+|Gy| with saturation to SAT_MAX, or binarisation
// against THRESH when SOBEL_THRESH_EN is defined.
module sobel_mag_sat
   import sobel_pkg::*;
#(
   parameter int PIX_W   = 8,
   parameter int SAT_MAX = 255,
   parameter int THRESH  = 128
) (
   input  logic signed [ACC_W-1:0] in_acc_x,
   input  logic signed [ACC_W-1:0] in_acc_y,
   output logic        [PIX_W-1:0] out_pix
);

   logic [MAG_W-1:0] abs_x;
   logic [MAG_W-1:0] abs_y;
   logic [MAG_W-1:0] mag;

   always_comb begin
      // |acc| <= 1020, so the 11-bit truncation of the negation is exact
      abs_x = in_acc_x[ACC_W-1] ? MAG_W'(-in_acc_x) : MAG_W'(in_acc_x);
      abs_y = in_acc_y[ACC_W-1] ? MAG_W'(-in_acc_y) : MAG_W'(in_acc_y);
      mag   = abs_x + abs_y;
`ifdef SOBEL_THRESH_EN
      out_pix = (mag >= MAG_W'(THRESH)) ? {PIX_W{1'b1}} : '0;
`else
      out_pix = (mag > MAG_W'(SAT_MAX)) ? PIX_W'(SAT_MAX) : PIX_W'(mag);
`endif
   end

endmodule

// File: rtl/sobel_core_sched.sv
// Drives a shared 3-tap MAC core with 6 column beats per 3x3 window and
// builds the Sobel magnitude pixel. Optional macro: SOBEL_THRESH_EN.
module sobel_core_sched
   import sobel_pkg::*;
#(
   parameter int PIX_W    = 8,
   parameter int CORE_LAT = 2,
   parameter int SAT_MAX  = 255,
   parameter int THRESH   = 128
) (
   input  logic                    InClk,
   input  logic                    InRst,
   input  logic [9*PIX_W-1:0]      InWin,
   input  logic                    InWinValid,
   output logic                    InWinReady,
   output logic signed [PIX_W:0]   OutCoreData1,
   output logic signed [PIX_W:0]   OutCoreData2,
   output logic signed [PIX_W:0]   OutCoreData3,
   output logic signed [TAP_W-1:0] OutCoreK1,
   output logic signed [TAP_W-1:0] OutCoreK2,
   output logic signed [TAP_W-1:0] OutCoreK3,
   output logic                    OutCoreDe,
   input  logic signed [15:0]      InCoreData,
   input  logic                    InCoreDataDe,
   output logic [PIX_W-1:0]        OutPix,
   output logic                    OutPixValid,
   input  logic                    InPixReady,
   output logic                    OutBusy
);

   localparam int FL_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

   state_t                  state_q, state_d;
   logic [FL_W-1:0]         flush_q, flush_d;
   logic [2:0]              beat_q, beat_d;
   logic [2:0]              res_q, res_d;
   logic [9*PIX_W-1:0]      win_q, win_d;
   logic signed [ACC_W-1:0] acc_x_q, acc_x_d;
   logic signed [ACC_W-1:0] acc_y_q, acc_y_d;
   logic [PIX_W-1:0]        out_pix_q, out_pix_d;
   logic                    busy_q, busy_d;

   logic                    issue;
   logic                    res_in;
   logic                    pix_hs;
   logic signed [ACC_W-1:0] core_res;
   logic [PIX_W-1:0]        mag_pix;
   logic [1:0]              col;
   logic                    is_y;

   assign issue    = (state_q == ST_ISSUE);
   // Core latency is shorter than the beat train, so results land in ISSUE too
   assign res_in   = InCoreDataDe && (state_q == ST_ISSUE || state_q == ST_DRAIN);
   assign pix_hs   = (state_q == ST_OUT) && InPixReady;
   assign core_res = ACC_W'(InCoreData);

   always_comb begin
      res_d   = res_q;
      acc_x_d = acc_x_q;
      acc_y_d = acc_y_q;
      if (pix_hs) begin
         res_d   = '0;
         acc_x_d = '0;
         acc_y_d = '0;
      end else if (res_in) begin
         res_d = res_q + 3'd1;
         if (res_q < 3'd3) acc_x_d = acc_x_q + core_res;
         else              acc_y_d = acc_y_q + core_res;
      end
   end

   // Fed with acc_y_d so the final Gy result is folded in on its arrival cycle
   sobel_mag_sat #(
      .PIX_W   (PIX_W),
      .SAT_MAX (SAT_MAX),
      .THRESH  (THRESH)
   ) u_mag (
      .in_acc_x (acc_x_q),
      .in_acc_y (acc_y_d),
      .out_pix  (mag_pix)
   );

   always_comb begin
      state_d    = state_q;
      flush_d    = flush_q;
      beat_d     = beat_q;
      win_d      = win_q;
      out_pix_d  = out_pix_q;
      InWinReady = 1'b0;
      case (state_q)
         ST_FLUSH: begin
            flush_d = flush_q + 1'b1;
            if (flush_q == FL_W'(CORE_LAT - 1)) begin
               flush_d = '0;
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            InWinReady = 1'b1;
            if (InWinValid) begin
               win_d   = InWin;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            beat_d = beat_q + 3'd1;
            if (beat_q == 3'd5) begin
               beat_d  = '0;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (res_in && res_q == 3'd5) begin
               out_pix_d = mag_pix;
               state_d   = ST_OUT;
            end
         end
         ST_OUT: begin
            if (InPixReady) begin
               out_pix_d = '0;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_FLUSH;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_comb begin
      col          = (beat_q < 3'd3) ? beat_q[1:0] : 2'(beat_q - 3'd3);
      is_y         = (beat_q >= 3'd3);
      OutCoreData1 = '0;
      OutCoreData2 = '0;
      OutCoreData3 = '0;
      OutCoreK1    = '0;
      OutCoreK2    = '0;
      OutCoreK3    = '0;
      if (issue) begin
         OutCoreData1 = {1'b0, win_q[PIX_W*int'(col) +: PIX_W]};
         OutCoreData2 = {1'b0, win_q[PIX_W*(3 + int'(col)) +: PIX_W]};
         OutCoreData3 = {1'b0, win_q[PIX_W*(6 + int'(col)) +: PIX_W]};
         OutCoreK1    = sobel_tap(is_y, col, 2'd0);
         OutCoreK2    = sobel_tap(is_y, col, 2'd1);
         OutCoreK3    = sobel_tap(is_y, col, 2'd2);
      end
   end

   assign OutCoreDe   = issue;
   assign OutPixValid = (state_q == ST_OUT);
   assign OutPix      = out_pix_q;
   assign OutBusy     = busy_q;

   always_ff @(posedge InClk) begin
      if (InRst) begin
         state_q   <= ST_FLUSH;
         flush_q   <= '0;
         beat_q    <= '0;
         res_q     <= '0;
         win_q     <= '0;
         acc_x_q   <= '0;
         acc_y_q   <= '0;
         out_pix_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         flush_q   <= flush_d;
         beat_q    <= beat_d;
         res_q     <= res_d;
         win_q     <= win_d;
         acc_x_q   <= acc_x_d;
         acc_y_q   <= acc_y_d;
         out_pix_q <= out_pix_d;
         busy_q    <= busy_d;
      end
   end

`ifndef SYNTHESIS
   // Stray results in FLUSH are expected after a mid-operation reset
   always_ff @(posedge InClk) begin
      if (!InRst && InCoreDataDe)
         assert (state_q inside {ST_FLUSH, ST_ISSUE, ST_DRAIN})
         else $error("core result arrived outside ISSUE/DRAIN");
   end
`endif

endmodule

// File: tb/tb_sobel_core_sched.sv
// Directed bench for sobel_core_sched with a 2-cycle behavioural MAC core.
module tb_sobel_core_sched;

   logic              InClk = 1'b0;
   logic              InRst;
   logic [71:0]       InWin;
   logic              InWinValid;
   logic              InWinReady;
   logic signed [8:0] OutCoreData1, OutCoreData2, OutCoreData3;
   logic signed [2:0] OutCoreK1, OutCoreK2, OutCoreK3;
   logic              OutCoreDe;
   logic signed [15:0] InCoreData;
   logic              InCoreDataDe;
   logic [7:0]        OutPix;
   logic              OutPixValid;
   logic              InPixReady;
   logic              OutBusy;

   always #5 InClk = ~InClk;

   sobel_core_sched dut (
      .InClk        (InClk),
      .InRst        (InRst),
      .InWin        (InWin),
      .InWinValid   (InWinValid),
      .InWinReady   (InWinReady),
      .OutCoreData1 (OutCoreData1),
      .OutCoreData2 (OutCoreData2),
      .OutCoreData3 (OutCoreData3),
      .OutCoreK1    (OutCoreK1),
      .OutCoreK2    (OutCoreK2),
      .OutCoreK3    (OutCoreK3),
      .OutCoreDe    (OutCoreDe),
      .InCoreData   (InCoreData),
      .InCoreDataDe (InCoreDataDe),
      .OutPix       (OutPix),
      .OutPixValid  (OutPixValid),
      .InPixReady   (InPixReady),
      .OutBusy      (OutBusy)
   );

   // Behavioural core: 3 products plus sum, 2-cycle latency, never reset
   logic signed [15:0] core_sum;
   logic signed [15:0] p1_d = '0, p2_d = '0;
   logic               p1_de = 1'b0, p2_de = 1'b0;

   always_comb
      core_sum = 16'(OutCoreData1) * 16'(OutCoreK1)
               + 16'(OutCoreData2) * 16'(OutCoreK2)
               + 16'(OutCoreData3) * 16'(OutCoreK3);

   always @(posedge InClk) begin
      p1_de <= OutCoreDe;
      p1_d  <= core_sum;
      p2_de <= p1_de;
      p2_d  <= p1_d;
   end

   assign InCoreDataDe = p2_de;
   assign InCoreData   = p2_d;

   logic [8:0] tap_log[$];
   logic [8:0] d1_log[$];

   always @(posedge InClk) begin
      if (OutCoreDe) begin
         tap_log.push_back({OutCoreK1, OutCoreK2, OutCoreK3});
         d1_log.push_back(OutCoreData1);
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge InClk);
      #1;
   endtask

   function automatic logic [71:0] win_cols(input logic [7:0] c0, input logic [7:0] c1,
                                            input logic [7:0] c2);
      logic [71:0] w;
      for (int r = 0; r < 3; r++) begin
         w[8*(3*r+0) +: 8] = c0;
         w[8*(3*r+1) +: 8] = c1;
         w[8*(3*r+2) +: 8] = c2;
      end
      return w;
   endfunction

   function automatic logic [71:0] win_rows(input logic [7:0] r0, input logic [7:0] r1,
                                            input logic [7:0] r2);
      logic [71:0] w;
      for (int c = 0; c < 3; c++) begin
         w[8*(0+c) +: 8] = r0;
         w[8*(3+c) +: 8] = r1;
         w[8*(6+c) +: 8] = r2;
      end
      return w;
   endfunction

   function automatic int exp_pix(input int mag);
`ifdef SOBEL_THRESH_EN
      return (mag >= 128) ? 255 : 0;
`else
      return (mag > 255) ? 255 : mag;
`endif
   endfunction

   task automatic send_win(input logic [71:0] w, input string tag);
      int n;
      int lat;
      InWin      = w;
      InWinValid = 1'b1;
      n = 0;
      while (!InWinReady && n < 20) begin
         step();
         n++;
      end
      chk({tag, " win_ready"}, 32'(InWinReady), 1);
      step();
      InWinValid = 1'b0;
      chk({tag, " busy"}, 32'(OutBusy), 1);
      lat = 1;
      while (!OutPixValid && lat < 40) begin
         step();
         lat++;
      end
      chk({tag, " latency"}, lat, 9);
   endtask

   task automatic take_pix(input string tag, input int exp, input int hold);
      chk({tag, " pix_valid"}, 32'(OutPixValid), 1);
      chk({tag, " pix"}, 32'(OutPix), exp);
      for (int i = 0; i < hold; i++) begin
         InWinValid = 1'b1;
         step();
         chk({tag, " hold valid"}, 32'(OutPixValid), 1);
         chk({tag, " hold pix"}, 32'(OutPix), exp);
         chk({tag, " hold win_ready"}, 32'(InWinReady), 0);
      end
      InWinValid = 1'b0;
      InPixReady = 1'b1;
      step();
      InPixReady = 1'b0;
      chk({tag, " post valid"}, 32'(OutPixValid), 0);
      chk({tag, " post win_ready"}, 32'(InWinReady), 1);
      chk({tag, " post busy"}, 32'(OutBusy), 0);
   endtask

   task automatic wait_flush(input string tag);
      int n;
      n = 0;
      while (!InWinReady && n < 10) begin
         step();
         n++;
      end
      chk({tag, " flush cycles"}, n, 2);
   endtask

   initial begin
      InRst      = 1'b1;
      InWin      = '0;
      InWinValid = 1'b0;
      InPixReady = 1'b0;
      repeat (3) step();

      chk("rst win_ready", 32'(InWinReady), 0);
      chk("rst pix_valid", 32'(OutPixValid), 0);
      chk("rst pix", 32'(OutPix), 0);
      chk("rst core_de", 32'(OutCoreDe), 0);
      chk("rst busy", 32'(OutBusy), 0);
      chk("rst k1", 32'(OutCoreK1), 0);

      InRst = 1'b0;
      wait_flush("init");

      // 1: flat window, no gradient
      send_win(win_cols(8'd100, 8'd100, 8'd100), "c1");
      take_pix("c1", exp_pix(0), 0);

      // 2: columns 0/5/10 -> Gx=40, also checks row-0 operand order
      tap_log.delete();
      d1_log.delete();
      send_win(win_cols(8'd0, 8'd5, 8'd10), "c2");
      take_pix("c2", exp_pix(40), 0);
      chk("c2 beats", d1_log.size(), 6);
      chk("c2 d1 b0", 32'(d1_log[0]), 0);
      chk("c2 d1 b1", 32'(d1_log[1]), 5);
      chk("c2 d1 b2", 32'(d1_log[2]), 10);
      chk("c2 d1 b4", 32'(d1_log[4]), 5);

      // 3: max horizontal edge, Gx=1020 saturates
      send_win(win_cols(8'd0, 8'd0, 8'd255), "c3");
      take_pix("c3", exp_pix(1020), 0);

      // 4: rows 0/7/20 -> Gx=0, Gy=80; taps K1,K2,K3 per beat
      tap_log.delete();
      send_win(win_rows(8'd0, 8'd7, 8'd20), "c4");
      take_pix("c4", exp_pix(80), 0);
      chk("c4 beats", tap_log.size(), 6);
      chk("c4 tap b0", 32'(tap_log[0]), 9'b111_110_111);
      chk("c4 tap b1", 32'(tap_log[1]), 9'b000_000_000);
      chk("c4 tap b2", 32'(tap_log[2]), 9'b001_010_001);
      chk("c4 tap b3", 32'(tap_log[3]), 9'b111_000_001);
      chk("c4 tap b4", 32'(tap_log[4]), 9'b110_000_010);
      chk("c4 tap b5", 32'(tap_log[5]), 9'b111_000_001);

      // 5: downstream stall in OUT for 5 cycles
      send_win(win_cols(8'd0, 8'd0, 8'd255), "c5");
      take_pix("c5", exp_pix(1020), 5);

      // 6: reset during beat 3, in-flight results must be dropped
      InWin      = win_rows(8'd0, 8'd7, 8'd20);
      InWinValid = 1'b1;
      chk("c6 win_ready", 32'(InWinReady), 1);
      step();
      InWinValid = 1'b0;
      repeat (3) step();
      chk("c6 beat3 de", 32'(OutCoreDe), 1);
      InRst = 1'b1;
      step();
      InRst = 1'b0;
      chk("c6 rst core_de", 32'(OutCoreDe), 0);
      chk("c6 rst pix_valid", 32'(OutPixValid), 0);
      chk("c6 rst pix", 32'(OutPix), 0);
      chk("c6 rst win_ready", 32'(InWinReady), 0);
      wait_flush("c6");
      send_win(win_cols(8'd0, 8'd5, 8'd10), "c6b");
      take_pix("c6b", exp_pix(40), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
